// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALUCtl codes, forwarding selects and the ID/EX register layout.
package mips_pkg;
    localparam int XLEN  = 32;
    localparam int RADDR = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_NOR = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRA = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [3:0]       alu_ctl;
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  imm;
        logic             alu_src;
        logic [4:0]       shamt;
        logic [RADDR-1:0] rs;
        logic [RADDR-1:0] rt;
        logic [RADDR-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } idex_t;

    // Register 0 is hardwired, so a write to it is never a forwarding source.
    function automatic logic fwd_hit(logic we, logic [RADDR-1:0] dest, logic [RADDR-1:0] src);
        return we && dest != '0 && dest == src;
    endfunction
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the bypass source for one operand, MEM before WB before register.
module forward_unit
    import mips_pkg::*;
(
    input  logic [RADDR-1:0] src,
    input  logic             mem_reg_write,
    input  logic [RADDR-1:0] mem_dest,
    input  logic             wb_reg_write,
    input  logic [RADDR-1:0] wb_dest,
    output logic [1:0]       sel
);
    assign sel = fwd_hit(mem_reg_write, mem_dest, src) ? FWD_MEM :
                 fwd_hit(wb_reg_write, wb_dest, src)   ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with capture-time WB bypass, EX operand forwarding
// and load-use stall generation.
module ex_operand_stage
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [3:0]       id_alu_ctl,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alu_src,
    input  logic [4:0]       id_shamt,
    input  logic [RADDR-1:0] id_rs,
    input  logic [RADDR-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [RADDR-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    input  logic             mem_reg_write,
    input  logic [RADDR-1:0] mem_dest,
    input  logic [XLEN-1:0]  mem_result,
    input  logic             wb_reg_write,
    input  logic [RADDR-1:0] wb_dest,
    input  logic [XLEN-1:0]  wb_result,
    output logic [3:0]       alu_ctl,
    output logic [XLEN-1:0]  alu_a,
    output logic [XLEN-1:0]  alu_b,
    output logic [4:0]       alu_shamt,
    output logic [XLEN-1:0]  ex_store_data,
    output logic [RADDR-1:0] ex_dest,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_valid,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall
);
    idex_t           ex_q;
    logic            go;
    logic [XLEN-1:0] fwd_rs, fwd_rt;

    // A load in EX whose result the ID instruction needs: hold ID for one bubble.
    assign stall = ex_q.valid && ex_q.mem_read && ex_q.dest != '0 && id_valid && !flush &&
                   (ex_q.dest == id_rs || (id_uses_rt && ex_q.dest == id_rt));
    assign go    = id_valid && !flush && !stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= '{valid:     go,
                      alu_ctl:   id_alu_ctl,
                      rs_data:   fwd_hit(wb_reg_write, wb_dest, id_rs) ? wb_result : id_rs_data,
                      rt_data:   fwd_hit(wb_reg_write, wb_dest, id_rt) ? wb_result : id_rt_data,
                      imm:       id_imm,
                      alu_src:   id_alu_src,
                      shamt:     id_shamt,
                      rs:        id_rs,
                      rt:        id_rt,
                      dest:      id_dest,
                      reg_write: go && id_reg_write,
                      mem_read:  go && id_mem_read};
    end

    forward_unit u_fwd_a (
        .src(ex_q.rs), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .sel(fwd_a_sel)
    );

    forward_unit u_fwd_b (
        .src(ex_q.rt), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .sel(fwd_b_sel)
    );

    assign fwd_rs = fwd_a_sel == FWD_MEM ? mem_result : fwd_a_sel == FWD_WB ? wb_result : ex_q.rs_data;
    assign fwd_rt = fwd_b_sel == FWD_MEM ? mem_result : fwd_b_sel == FWD_WB ? wb_result : ex_q.rt_data;

    assign alu_ctl       = ex_q.alu_ctl;
    assign alu_shamt     = ex_q.shamt;
    assign alu_a         = fwd_rs;
    assign alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_dest       = ex_q.dest;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_valid      = ex_q.valid;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: scoreboard bench; expected ID/EX contents are queued at drive time
// and compared, with a forwarding model, once the edge has moved them into EX.
module tb_ex_operand_stage;
    typedef struct packed {
        logic        valid;
        logic [3:0]  ctl;
        logic [31:0] rsd, rtd, imm;
        logic        src;
        logic [4:0]  shamt, rs, rt, dest;
        logic        rw, mr;
    } rec_t;

    logic        clk = 0, rst_n = 0;
    logic        id_valid = 0, id_alu_src = 0, id_uses_rt = 0, id_reg_write = 0, id_mem_read = 0, flush = 0;
    logic [3:0]  id_alu_ctl = 0;
    logic [31:0] id_rs_data = 0, id_rt_data = 0, id_imm = 0, mem_result = 0, wb_result = 0;
    logic [4:0]  id_shamt = 0, id_rs = 0, id_rt = 0, id_dest = 0, mem_dest = 0, wb_dest = 0;
    logic        mem_reg_write = 0, wb_reg_write = 0;
    logic [3:0]  alu_ctl;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_shamt, ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_valid, stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int   total = 0, bad = 0;
    rec_t q[$];
    rec_t cur = '0;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_ctl(id_alu_ctl),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_dest(id_dest), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .flush(flush), .mem_reg_write(mem_reg_write),
        .mem_dest(mem_dest), .mem_result(mem_result), .wb_reg_write(wb_reg_write),
        .wb_dest(wb_dest), .wb_result(wb_result), .alu_ctl(alu_ctl), .alu_a(alu_a),
        .alu_b(alu_b), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_valid(ex_valid), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fsel(input logic [4:0] a);
        if (mem_reg_write && mem_dest != 0 && mem_dest == a) return 2'b10;
        if (wb_reg_write && wb_dest != 0 && wb_dest == a) return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_fwd();
        logic [1:0]  sa, sb;
        logic [31:0] fa, fb;
        #1;
        sa = fsel(cur.rs);
        sb = fsel(cur.rt);
        fa = sa == 2'b10 ? mem_result : sa == 2'b01 ? wb_result : cur.rsd;
        fb = sb == 2'b10 ? mem_result : sb == 2'b01 ? wb_result : cur.rtd;
        check("fwd_a_sel", 32'(fwd_a_sel), 32'(sa));
        check("fwd_b_sel", 32'(fwd_b_sel), 32'(sb));
        check("alu_a", alu_a, fa);
        check("alu_b", alu_b, cur.src ? cur.imm : fb);
        check("store_data", ex_store_data, fb);
    endtask

    task automatic drive(input logic v, input logic [3:0] ctl, input logic [31:0] rsd, rtd, imm,
                         input logic src, input logic [4:0] sh, rs, rt, input logic urt,
                         input logic [4:0] dst, input logic rw, mr);
        id_valid = v; id_alu_ctl = ctl; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
        id_alu_src = src; id_shamt = sh; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = dst; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic fwd_in(input logic mw, input logic [4:0] md, input logic [31:0] mr,
                          input logic ww, input logic [4:0] wd, input logic [31:0] wr);
        mem_reg_write = mw; mem_dest = md; mem_result = mr;
        wb_reg_write = ww; wb_dest = wd; wb_result = wr;
    endtask

    task automatic tick();
        rec_t r;
        logic st;
        #1;
        st = cur.valid && cur.mr && cur.dest != 0 && id_valid && !flush &&
             (cur.dest == id_rs || (id_uses_rt && cur.dest == id_rt));
        check("stall", 32'(stall), 32'(st));
        r.valid = id_valid && !flush && !st;
        r.ctl = id_alu_ctl;
        r.rsd = (wb_reg_write && wb_dest != 0 && wb_dest == id_rs) ? wb_result : id_rs_data;
        r.rtd = (wb_reg_write && wb_dest != 0 && wb_dest == id_rt) ? wb_result : id_rt_data;
        r.imm = id_imm; r.src = id_alu_src; r.shamt = id_shamt;
        r.rs = id_rs; r.rt = id_rt; r.dest = id_dest;
        r.rw = r.valid && id_reg_write;
        r.mr = r.valid && id_mem_read;
        q.push_back(r);
        @(posedge clk);
        #1;
        cur = q.pop_front();
        check("alu_ctl", 32'(alu_ctl), 32'(cur.ctl));
        check("alu_shamt", 32'(alu_shamt), 32'(cur.shamt));
        check("ex_dest", 32'(ex_dest), 32'(cur.dest));
        check("ex_valid", 32'(ex_valid), 32'(cur.valid));
        check("ex_reg_write", 32'(ex_reg_write), 32'(cur.rw));
        check("ex_mem_read", 32'(ex_mem_read), 32'(cur.mr));
        check_fwd();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"}, 32'(alu_ctl), 0);
        check({tag, "_valid"}, 32'(ex_valid), 0);
        check({tag, "_rw"}, 32'(ex_reg_write), 0);
        check({tag, "_mr"}, 32'(ex_mem_read), 0);
        check({tag, "_dest"}, 32'(ex_dest), 0);
        check({tag, "_shamt"}, 32'(alu_shamt), 0);
        check({tag, "_a"}, alu_a, 0);
        check({tag, "_b"}, alu_b, 0);
        check({tag, "_stall"}, 32'(stall), 0);
    endtask

    initial begin
        #2;
        check_zero("por");
        @(negedge clk);
        rst_n = 1;
        // Mid-stream reset: a valid load sits in EX, reset must clear it without a clock.
        drive(1, 4'b0010, 32'h11, 32'h22, 32'h33, 1, 5'd7, 5'd1, 5'd2, 1, 5'd9, 1, 1);
        tick();
        check("pre_rst_valid", 32'(ex_valid), 1);
        rst_n = 0;
        #1;
        check_zero("rst");
        cur = '0;
        q.delete();
        #1 rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // sub $4,$3,$1 with stale rs data; MEM supplies $3, then MEM vs WB priority.
        drive(1, 4'b0011, 32'h0, 32'h5, 0, 0, 0, 5'd3, 5'd1, 1, 5'd4, 1, 0);
        tick();
        fwd_in(1, 5'd3, 32'h10, 0, 0, 0);
        check_fwd();
        check("mem_fwd_a", alu_a, 32'h10);
        check("mem_fwd_sel", 32'(fwd_a_sel), 32'b10);
        fwd_in(1, 5'd3, 32'h10, 1, 5'd3, 32'h20);
        check_fwd();
        check("mem_over_wb", alu_a, 32'h10);
        fwd_in(0, 5'd3, 32'h10, 1, 5'd3, 32'h20);
        check_fwd();
        check("wb_fwd_a", alu_a, 32'h20);
        fwd_in(0, 0, 0, 0, 0, 0);

        // lw $5 then add $6,$7,$5: one bubble, then load data arrives on the rt path.
        drive(1, 4'b0010, 32'h100, 0, 32'h4, 1, 0, 5'd1, 5'd5, 0, 5'd5, 1, 1);
        tick();
        drive(1, 4'b0010, 32'h7, 32'h0, 0, 0, 0, 5'd7, 5'd5, 1, 5'd6, 1, 0);
        #1;
        check("lu_stall", 32'(stall), 1);
        tick();
        check("lu_bubble", 32'(ex_valid), 0);
        check("lu_unstall", 32'(stall), 0);
        tick();
        fwd_in(1, 5'd5, 32'hCAFE_0005, 0, 0, 0);
        check_fwd();
        check("lu_alu_b", alu_b, 32'hCAFE_0005);
        check("lu_b_sel", 32'(fwd_b_sel), 32'b10);
        check("lu_valid", 32'(ex_valid), 1);
        fwd_in(0, 0, 0, 0, 0, 0);

        // $0 is never forwarded and lw $0 never stalls.
        drive(1, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 1, 1);
        tick();
        fwd_in(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF);
        check_fwd();
        check("r0_sel", 32'(fwd_a_sel), 0);
        check("r0_a", alu_a, 0);
        fwd_in(0, 0, 0, 0, 0, 0);
        drive(1, 4'b0010, 32'h0, 32'h0, 0, 0, 0, 5'd0, 5'd0, 1, 5'd2, 1, 0);
        #1;
        check("r0_nostall", 32'(stall), 0);

        // Immediate plus shift.
        drive(1, 4'b0110, 32'h1, 32'h99, 32'h5, 1, 5'd5, 5'd1, 5'd2, 0, 5'd3, 1, 0);
        tick();
        check("imm_b", alu_b, 32'h5);
        check("imm_shamt", 32'(alu_shamt), 5);
        check("imm_ctl", 32'(alu_ctl), 32'b0110);

        // Flush over a load-use pair gives one bubble; then WB bypass at capture.
        drive(1, 4'b0010, 0, 0, 0, 0, 0, 5'd1, 5'd0, 0, 5'd8, 1, 1);
        tick();
        drive(1, 4'b0010, 0, 0, 0, 0, 0, 5'd8, 5'd0, 0, 5'd10, 1, 0);
        flush = 1;
        tick();
        flush = 0;
        check("flush_rw", 32'(ex_reg_write), 0);
        check("flush_valid", 32'(ex_valid), 0);
        drive(1, 4'b0000, 32'h1234, 32'h0, 0, 0, 0, 5'd9, 5'd0, 0, 5'd11, 1, 0);
        fwd_in(0, 0, 0, 1, 5'd9, 32'hDEAD_BEEF);
        tick();
        fwd_in(0, 0, 0, 0, 0, 0);
        check_fwd();
        check("wbcap_a", alu_a, 32'hDEAD_BEEF);
        check("wbcap_sel", 32'(fwd_a_sel), 0);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 9)), $urandom, $urandom, $urandom,
                  1'($urandom), 5'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 7) == 0);
            fwd_in(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            tick();
            fwd_in(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                   1'($urandom), 5'($urandom_range(0, 3)), $urandom);
            check_fwd();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
